// File: rtl/seg7_scan_reader.sv
// seg7_scan_reader
// Watches a multiplexed 7-segment bus (segments plus one-hot digit enables),
// decodes each digit back to BCD and accepts a digit once it has shown the
// same pattern on STABLE_CNT consecutive samples. When every digit has
// committed, the frame is frozen on bcd_out/err_out and offered through a
// valid/ready handshake.
module seg7_scan_reader #(
  parameter int DIGITS     = 4,
  parameter int STABLE_CNT = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sample,
  input  logic [6:0]            seg_in,
  input  logic [DIGITS-1:0]     dig_en,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     err_out,
  output logic                  frame_valid,
  input  logic                  frame_ready
);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  localparam logic [3:0] STABLE_C  = 4'(STABLE_CNT);
  // Invalid flag set, nibble F: the "unknown" code used for reset and bad patterns
  localparam logic [4:0] CODE_BAD  = 5'h1F;

  // Map an active-high a..g pattern to {invalid, bcd}
  function automatic logic [4:0] decode_seg(input logic [6:0] seg);
    logic [4:0] code;
    case (seg)
      7'b1111110: code = 5'h00;
      7'b0110000: code = 5'h01;
      7'b1101101: code = 5'h02;
      7'b1111001: code = 5'h03;
      7'b0110011: code = 5'h04;
      7'b1011011: code = 5'h05;
      7'b1011111: code = 5'h06;
      7'b1110000: code = 5'h07;
      7'b1111111: code = 5'h08;
      7'b1111011: code = 5'h09;
      default:    code = CODE_BAD;
    endcase
    return code;
  endfunction

  state_t                   state_r, state_s;
  logic [DIGITS-1:0][4:0]   cand_r, cand_s;
  logic [DIGITS-1:0][3:0]   cnt_r, cnt_s;
  logic [DIGITS-1:0][4:0]   shadow_r, shadow_s;
  logic [DIGITS-1:0]        committed_r, committed_s;
  logic [DIGITS-1:0]        commit_s;
  logic [4*DIGITS-1:0]      bcd_r, bcd_s;
  logic [DIGITS-1:0]        err_r, err_s;
  logic                     frame_valid_r;
  logic [4:0]               code_s;
  logic                     onehot_s;
  logic                     load_s;
  logic                     handshake_s;

  assign code_s   = decode_seg(seg_in);
  assign onehot_s = (dig_en != {DIGITS{1'b0}}) &&
                    ((dig_en & (dig_en - DIGITS'(1))) == {DIGITS{1'b0}});

  // Per-digit candidate/stability tracking and commit detection for this edge
  always_comb begin
    cand_s   = cand_r;
    cnt_s    = cnt_r;
    shadow_s = shadow_r;
    commit_s = {DIGITS{1'b0}};
    for (int i = 0; i < DIGITS; i++) begin
      if (sample && onehot_s && dig_en[i]) begin
        if (code_s == cand_r[i]) begin
          if (cnt_r[i] != STABLE_C) begin
            cnt_s[i] = cnt_r[i] + 4'd1;
          end else begin
            cnt_s[i] = cnt_r[i];
          end
        end else begin
          cand_s[i] = code_s;
          cnt_s[i]  = 4'd1;
        end
        // A saturated digit re-commits on every matching sample
        if (cnt_s[i] == STABLE_C) begin
          commit_s[i] = 1'b1;
          shadow_s[i] = code_s;
        end else begin
          commit_s[i] = 1'b0;
        end
      end else begin
        commit_s[i] = 1'b0;
      end
    end
  end

  // Frame FSM: committed set bookkeeping, next state and output load
  always_comb begin
    state_s     = state_r;
    load_s      = 1'b0;
    handshake_s = (state_r == HOLD) && frame_ready;
    // Clear happens before this edge's commits so they count toward the next frame
    if (handshake_s) begin
      committed_s = commit_s;
    end else begin
      committed_s = committed_r | commit_s;
    end
    case (state_r)
      COLLECT: begin
        if (&committed_s) begin
          state_s = HOLD;
          load_s  = 1'b1;
        end else begin
          state_s = COLLECT;
        end
      end
      HOLD: begin
        if (frame_ready) begin
          state_s = COLLECT;
        end else begin
          state_s = HOLD;
        end
      end
      default: state_s = COLLECT;
    endcase
  end

  // Flatten the shadow codes into the output frame layout
  always_comb begin
    bcd_s = {(4*DIGITS){1'b0}};
    err_s = {DIGITS{1'b0}};
    for (int i = 0; i < DIGITS; i++) begin
      bcd_s[4*i +: 4] = shadow_s[i][3:0];
      err_s[i]        = shadow_s[i][4];
    end
  end

  // Sequential state: digit trackers, FSM and frozen output frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= COLLECT;
      cand_r        <= {DIGITS{CODE_BAD}};
      cnt_r         <= {DIGITS{4'd0}};
      shadow_r      <= {DIGITS{CODE_BAD}};
      committed_r   <= {DIGITS{1'b0}};
      bcd_r         <= {(4*DIGITS){1'b1}};
      err_r         <= {DIGITS{1'b1}};
      frame_valid_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      cand_r        <= cand_s;
      cnt_r         <= cnt_s;
      shadow_r      <= shadow_s;
      committed_r   <= committed_s;
      frame_valid_r <= (state_s == HOLD);
      if (load_s) begin
        bcd_r <= bcd_s;
        err_r <= err_s;
      end else begin
        bcd_r <= bcd_r;
        err_r <= err_r;
      end
    end
  end

  assign bcd_out     = bcd_r;
  assign err_out     = err_r;
  assign frame_valid = frame_valid_r;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Directed bench for seg7_scan_reader (DIGITS=4, STABLE_CNT=3).
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_seg7_scan_reader;

  localparam logic [6:0] P0 = 7'b1111110;
  localparam logic [6:0] P1 = 7'b0110000;
  localparam logic [6:0] P2 = 7'b1101101;
  localparam logic [6:0] P3 = 7'b1111001;
  localparam logic [6:0] P4 = 7'b0110011;
  localparam logic [6:0] P6 = 7'b1011111;
  localparam logic [6:0] P8 = 7'b1111111;
  localparam logic [6:0] P9 = 7'b1111011;
  localparam logic [6:0] PG = 7'b0000001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sample;
  logic [6:0]  seg_in;
  logic [3:0]  dig_en;
  logic [15:0] bcd_out;
  logic [3:0]  err_out;
  logic        frame_valid;
  logic        frame_ready;

  int tests = 0;
  int fails = 0;

  seg7_scan_reader #(.DIGITS(4), .STABLE_CNT(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample      (sample),
    .seg_in      (seg_in),
    .dig_en      (dig_en),
    .bcd_out     (bcd_out),
    .err_out     (err_out),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One sample strobe on the next rising edge; returns on the following falling edge
  task automatic samp(input logic [3:0] en, input logic [6:0] p);
    sample = 1'b1;
    dig_en = en;
    seg_in = p;
    @(negedge clk);
    sample = 1'b0;
    dig_en = 4'b0000;
  endtask

  task automatic round(input logic [6:0] a, input logic [6:0] b,
                       input logic [6:0] c, input logic [6:0] d);
    samp(4'b0001, a);
    samp(4'b0010, b);
    samp(4'b0100, c);
    samp(4'b1000, d);
  endtask

  // Same round, each valid sample preceded by a malformed enable carrying P0
  task automatic round_bad(input logic [6:0] a, input logic [6:0] b,
                           input logic [6:0] c, input logic [6:0] d);
    samp(4'b0000, P0); samp(4'b0001, a);
    samp(4'b0110, P0); samp(4'b0010, b);
    samp(4'b0000, P0); samp(4'b0100, c);
    samp(4'b0110, P0); samp(4'b1000, d);
  endtask

  task automatic handshake();
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; sample = 1'b0; seg_in = 7'd0; dig_en = 4'd0; frame_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_fv",  32'(frame_valid), 32'h0);
    chk("rst_bcd", 32'(bcd_out), 32'hFFFF);
    chk("rst_err", 32'(err_out), 32'hF);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic frame: 1,2,3,4 for three rounds
    round(P1, P2, P3, P4);
    round(P1, P2, P3, P4);
    samp(4'b0001, P1); samp(4'b0010, P2); samp(4'b0100, P3);
    chk("t1_fv_11", 32'(frame_valid), 32'h0);
    samp(4'b1000, P4);
    chk("t1_fv", 32'(frame_valid), 32'h1);
    chk("t1_bcd", 32'(bcd_out), 32'h4321);
    chk("t1_err", 32'(err_out), 32'h0);
    repeat (3) @(negedge clk);
    chk("t1_hold_fv", 32'(frame_valid), 32'h1);
    chk("t1_hold_bcd", 32'(bcd_out), 32'h4321);
    handshake();
    chk("t1_hs_fv", 32'(frame_valid), 32'h0);

    // Digit 2 flickering never commits; then steady 6
    round(P1, P2, P0, P4);
    round(P1, P2, P1, P4);
    round(P1, P2, P0, P4);
    chk("t2_flicker_fv", 32'(frame_valid), 32'h0);
    round(P1, P2, P6, P4);
    round(P1, P2, P6, P4);
    chk("t2_fv_r2", 32'(frame_valid), 32'h0);
    round(P1, P2, P6, P4);
    chk("t2_fv", 32'(frame_valid), 32'h1);
    chk("t2_bcd", 32'(bcd_out), 32'h4621);
    handshake();

    // Digit 1 shows an unrecognised pattern
    round(P1, PG, P6, P4);
    round(P1, PG, P6, P4);
    chk("t3_fv_r2", 32'(frame_valid), 32'h0);
    round(P1, PG, P6, P4);
    chk("t3_fv", 32'(frame_valid), 32'h1);
    chk("t3_bcd", 32'(bcd_out), 32'h46F1);
    chk("t3_err", 32'(err_out), 32'h2);
    handshake();

    // Saturated counts: one round suffices for the next frame
    samp(4'b0001, P1); samp(4'b0010, PG); samp(4'b0100, P6);
    chk("t4_fv_part", 32'(frame_valid), 32'h0);
    samp(4'b1000, P4);
    chk("t4_fv", 32'(frame_valid), 32'h1);
    chk("t4_bcd", 32'(bcd_out), 32'h46F1);
    handshake();

    // Digit 0 changes to 9: needs three matching samples
    round(P9, PG, P6, P4);
    round(P9, PG, P6, P4);
    chk("t5_fv_r2", 32'(frame_valid), 32'h0);
    chk("t5_bcd_r2", 32'(bcd_out), 32'h46F1);
    round(P9, PG, P6, P4);
    chk("t5_fv", 32'(frame_valid), 32'h1);
    chk("t5_bcd", 32'(bcd_out), 32'h46F9);

    // frame_ready held high: one frame per HOLD entry
    frame_ready = 1'b1;
    round(P9, PG, P6, P4);
    chk("t6_fv", 32'(frame_valid), 32'h1);
    chk("t6_bcd", 32'(bcd_out), 32'h46F9);
    @(negedge clk);
    chk("t6_fv_drop", 32'(frame_valid), 32'h0);
    frame_ready = 1'b0;

    // Malformed enables interleaved: digit 3 goes to 8
    round_bad(P9, PG, P6, P8);
    round_bad(P9, PG, P6, P8);
    chk("t7_fv_r2", 32'(frame_valid), 32'h0);
    round_bad(P9, PG, P6, P8);
    chk("t7_fv", 32'(frame_valid), 32'h1);
    chk("t7_bcd", 32'(bcd_out), 32'h86F9);
    chk("t7_err", 32'(err_out), 32'h2);

    // Reset during HOLD takes effect without a clock edge
    #1 rst_n = 1'b0;
    #1;
    chk("t8_fv", 32'(frame_valid), 32'h0);
    chk("t8_bcd", 32'(bcd_out), 32'hFFFF);
    chk("t8_err", 32'(err_out), 32'hF);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-collection discards progress
    round(P1, P2, P3, P4);
    #1 rst_n = 1'b0;
    #1;
    chk("t9_fv", 32'(frame_valid), 32'h0);
    chk("t9_bcd", 32'(bcd_out), 32'hFFFF);
    @(negedge clk);
    rst_n = 1'b1;
    round(P1, P2, P3, P4);
    round(P1, P2, P3, P4);
    chk("t9_fv_r2", 32'(frame_valid), 32'h0);
    round(P1, P2, P3, P4);
    chk("t9_fv_r3", 32'(frame_valid), 32'h1);
    chk("t9_bcd_r3", 32'(bcd_out), 32'h4321);
    chk("t9_err_r3", 32'(err_out), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
